// File: rtl/cache_ctrl_pkg.sv
// Shared types and default widths for the cache controller slice.
package cache_ctrl_pkg;

  localparam int unsigned TAG_LEN_DEF   = 8;
  localparam int unsigned IDX_LEN_DEF   = 6;
  localparam int unsigned DATA_LEN_DEF  = 32;
  localparam int unsigned CNT_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    WRITE,
    MEMREQ,
    MEMWAIT,
    FILL,
    RESP
  } state_e;

endpackage

// File: rtl/cache_ctrl_stats.sv
// Saturating hit/miss/write event counters for cache_ctrl (used under CACHE_CTRL_STATS_EN).
module cache_ctrl_stats
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned CNTWIDTH = CNT_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc_hit,
  input  logic                inc_miss,
  input  logic                inc_write,
  output logic [CNTWIDTH-1:0] hits,
  output logic [CNTWIDTH-1:0] misses,
  output logic [CNTWIDTH-1:0] writes
);

  localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hits   <= '0;
      misses <= '0;
      writes <= '0;
    end else begin
      if (inc_hit && hits != CNT_MAX)     hits   <= hits + CNTWIDTH'(1);
      if (inc_miss && misses != CNT_MAX)  misses <= misses + CNTWIDTH'(1);
      if (inc_write && writes != CNT_MAX) writes <= writes + CNTWIDTH'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Write-through, no-write-allocate CPU-side controller for the set-associative Cache.
// Define CACHE_CTRL_STATS_EN to add saturating stat_hits/stat_misses/stat_writes outputs.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned TAGLENGTH   = TAG_LEN_DEF,
  parameter int unsigned INDEXLENGTH = IDX_LEN_DEF,
  parameter int unsigned DATALENGTH  = DATA_LEN_DEF,
  parameter int unsigned CNTWIDTH    = CNT_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cpu_req_valid,
  output logic                             cpu_req_ready,
  input  logic                             cpu_we,
  input  logic [TAGLENGTH+INDEXLENGTH-1:0] cpu_addr,
  input  logic [DATALENGTH-1:0]            cpu_wdata,
  output logic                             cpu_rsp_valid,
  output logic [DATALENGTH-1:0]            cpu_rdata,
  output logic [TAGLENGTH-1:0]             c_tag,
  output logic [INDEXLENGTH-1:0]           c_index,
  output logic                             c_re,
  output logic                             c_we,
  output logic                             c_loade,
  output logic [DATALENGTH-1:0]            c_datain,
  input  logic                             c_hit,
  input  logic [DATALENGTH-1:0]            c_dataout,
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_we,
  output logic [TAGLENGTH+INDEXLENGTH-1:0] mem_addr,
  output logic [DATALENGTH-1:0]            mem_wdata,
  input  logic                             mem_rsp_valid,
  input  logic [DATALENGTH-1:0]            mem_rdata
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [CNTWIDTH-1:0]              stat_hits,
  output logic [CNTWIDTH-1:0]              stat_misses,
  output logic [CNTWIDTH-1:0]              stat_writes
`endif
);

  localparam int unsigned ADDR_W = TAGLENGTH + INDEXLENGTH;

  state_e                 state;
  logic [ADDR_W-1:0]      addr_q;
  logic                   we_q;
  logic [DATALENGTH-1:0]  wdata_q;
  logic [DATALENGTH-1:0]  rdata_q;

  // Cache and memory addressing come only from the latched request.
  assign c_tag     = addr_q[ADDR_W-1:INDEXLENGTH];
  assign c_index   = addr_q[INDEXLENGTH-1:0];
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Strobes are registered alongside the state they belong to, so each is high
  // exactly while the state register holds the matching state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cpu_req_ready <= 1'b1;
      cpu_rsp_valid <= 1'b0;
      cpu_rdata     <= '0;
      c_re          <= 1'b0;
      c_we          <= 1'b0;
      c_loade       <= 1'b0;
      c_datain      <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      rdata_q       <= '0;
    end else begin
      cpu_req_ready <= 1'b0;
      cpu_rsp_valid <= 1'b0;
      c_re          <= 1'b0;
      c_we          <= 1'b0;
      c_loade       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req_valid && cpu_req_ready) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            if (cpu_we) begin
              state    <= WRITE;
              c_we     <= 1'b1;
              c_datain <= cpu_wdata;
            end else begin
              state <= LOOKUP;
              c_re  <= 1'b1;
            end
          end else begin
            cpu_req_ready <= 1'b1;
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          // c_hit/c_dataout were registered by the Cache on the LOOKUP edge.
          if (c_hit) begin
            rdata_q       <= c_dataout;
            cpu_rdata     <= c_dataout;
            cpu_rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            mem_req_valid <= 1'b1;
            mem_we        <= we_q;
            state         <= MEMREQ;
          end
        end
        WRITE: begin
          mem_req_valid <= 1'b1;
          mem_we        <= we_q;
          state         <= MEMREQ;
        end
        MEMREQ: begin
          if (mem_req_ready) begin
            state <= MEMWAIT;
          end else begin
            mem_req_valid <= 1'b1;
            mem_we        <= we_q;
          end
        end
        MEMWAIT: begin
          if (mem_rsp_valid) begin
            if (we_q) begin
              cpu_rdata     <= '0;
              cpu_rsp_valid <= 1'b1;
              state         <= RESP;
            end else begin
              rdata_q  <= mem_rdata;
              c_datain <= mem_rdata;
              c_loade  <= 1'b1;
              state    <= FILL;
            end
          end
        end
        FILL: begin
          cpu_rdata     <= rdata_q;
          cpu_rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          cpu_req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  cache_ctrl_stats #(
    .CNTWIDTH(CNTWIDTH)
  ) u_stats (
    .clk      (clk),
    .reset    (reset),
    .inc_hit  (state == CHECK && c_hit),
    .inc_miss (state == CHECK && !c_hit),
    .inc_write(state == WRITE),
    .hits     (stat_hits),
    .misses   (stat_misses),
    .writes   (stat_writes)
  );
`else
  logic unused_cnt_cfg;
  assign unused_cnt_cfg = (CNTWIDTH != 0);
`endif

endmodule
